// File: rtl/isr_nest_stack.sv
// isr_nest_stack: tracks nested ISR entry/exit as a stack of IO module IDs.
// cur_id always reflects the innermost (currently serviced) module so the
// memory-access enable can be driven straight from it.
module isr_nest_stack #(
    parameter int ID_W    = 3,
    parameter int DEPTH   = 8,
    parameter int IDLE_ID = 0,
    parameter int PRIO_EN = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [ID_W-1:0]            push_id,
    input  logic                       pop,
    input  logic                       clr_err,
    output logic [ID_W-1:0]            cur_id,
    output logic                       active,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       full,
    output logic                       rejected,
    output logic                       overflow,
    output logic                       underflow
);
    localparam int DW = $clog2(DEPTH+1);
    localparam int AW = $clog2(DEPTH);
    localparam logic [DW-1:0]   DEPTH_V = DW'(DEPTH);
    localparam logic [ID_W-1:0] IDLE_V  = ID_W'(IDLE_ID);

    // Stack contents need no reset: entries above depth are never read.
    logic [DEPTH-1:0][ID_W-1:0] stack;

    logic [DW-1:0]   depth_d;
    logic [ID_W-1:0] cur_d;
    logic            we;
    logic [AW-1:0]   wr_idx;
    logic            rej_d, ovf_d, unf_d;
    logic            prio_ok;

    // Higher priority means numerically lower ID; an empty stack takes anything.
    assign prio_ok = (PRIO_EN == 0) || (depth == '0) || (push_id < cur_id);

    // Next-state decode for push/pop/replace and the error flags.
    always_comb begin
        depth_d = depth;
        cur_d   = cur_id;
        we      = 1'b0;
        wr_idx  = AW'(depth);
        rej_d   = 1'b0;
        ovf_d   = overflow;
        unf_d   = underflow;
        // Clear first so a same-cycle error event below wins.
        if (clr_err) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
        if (push && pop) begin
            if (depth != '0) begin
                // Outgoing ISR completes while a new one enters: swap the top.
                we     = 1'b1;
                wr_idx = AW'(depth - DW'(1));
                cur_d  = push_id;
            end else begin
                we      = 1'b1;
                wr_idx  = '0;
                depth_d = DW'(1);
                cur_d   = push_id;
                unf_d   = 1'b1;
            end
        end else if (push) begin
            if (depth == DEPTH_V) begin
                // Never overwrite the top entry when full.
                rej_d = 1'b1;
                ovf_d = 1'b1;
            end else if (prio_ok) begin
                we      = 1'b1;
                depth_d = depth + DW'(1);
                cur_d   = push_id;
            end else begin
                // Priority masking is normal operation, not an error.
                rej_d = 1'b1;
            end
        end else if (pop) begin
            if (depth == '0) begin
                unf_d = 1'b1;
            end else begin
                depth_d = depth - DW'(1);
                cur_d   = (depth >= DW'(2)) ? stack[AW'(depth - DW'(2))] : IDLE_V;
            end
        end
    end

    // Stack storage write.
    always_ff @(posedge clk) begin
        if (we) stack[wr_idx] <= push_id;
    end

    // Registered outputs; full/active come from next depth so they track depth exactly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            depth     <= '0;
            cur_id    <= IDLE_V;
            active    <= 1'b0;
            full      <= 1'b0;
            rejected  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            depth     <= depth_d;
            cur_id    <= cur_d;
            active    <= (depth_d != '0);
            full      <= (depth_d == DEPTH_V);
            rejected  <= rej_d;
            overflow  <= ovf_d;
            underflow <= unf_d;
        end
    end
endmodule

// File: tb/tb_isr_nest_stack.sv
// Directed bench for isr_nest_stack: one instance with priority checking,
// one without (for the fill-to-full scenario). Both share stimulus.
module tb_isr_nest_stack;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       push = 1'b0;
    logic [2:0] push_id = 3'd0;
    logic       pop = 1'b0;
    logic       clr_err = 1'b0;

    logic [2:0] a_cur, b_cur;
    logic [3:0] a_depth, b_depth;
    logic       a_active, a_full, a_rej, a_ovf, a_unf;
    logic       b_active, b_full, b_rej, b_ovf, b_unf;

    int errors = 0;
    int checks = 0;
    logic [11:0] got, exp;

    isr_nest_stack #(.ID_W(3), .DEPTH(8), .IDLE_ID(0), .PRIO_EN(1)) dut (
        .clk(clk), .reset(reset), .push(push), .push_id(push_id), .pop(pop),
        .clr_err(clr_err), .cur_id(a_cur), .active(a_active), .depth(a_depth),
        .full(a_full), .rejected(a_rej), .overflow(a_ovf), .underflow(a_unf)
    );

    isr_nest_stack #(.ID_W(3), .DEPTH(8), .IDLE_ID(0), .PRIO_EN(0)) dut0 (
        .clk(clk), .reset(reset), .push(push), .push_id(push_id), .pop(pop),
        .clr_err(clr_err), .cur_id(b_cur), .active(b_active), .depth(b_depth),
        .full(b_full), .rejected(b_rej), .overflow(b_ovf), .underflow(b_unf)
    );

    always #5 clk = ~clk;

    // Output snapshot: {cur_id, depth, active, full, rejected, overflow, underflow}
    function automatic logic [11:0] snap_a();
        return {a_cur, a_depth, a_active, a_full, a_rej, a_ovf, a_unf};
    endfunction
    function automatic logic [11:0] snap_b();
        return {b_cur, b_depth, b_active, b_full, b_rej, b_ovf, b_unf};
    endfunction
    function automatic logic [11:0] mk(input int c, input int d, input logic act,
                                       input logic f, input logic r, input logic o,
                                       input logic u);
        return {3'(c), 4'(d), act, f, r, o, u};
    endfunction

    task automatic step(input logic p, input int id, input logic po, input logic ce);
        push = p; push_id = 3'(id); pop = po; clr_err = ce;
        @(posedge clk); #1;
        push = 1'b0; pop = 1'b0; clr_err = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        checks++; got = snap_a(); exp = mk(0, 0, 0, 0, 0, 0, 0);
        if (got !== exp) begin errors++; $display("FAIL reset_a got=%h exp=%h", got, exp); end
        checks++; got = snap_b();
        if (got !== exp) begin errors++; $display("FAIL reset_b got=%h exp=%h", got, exp); end
        reset = 1'b0;
    endtask

    task automatic test_push_pop();
        int ids[3] = '{5, 3, 1};
        int pc[3]  = '{3, 5, 0};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, ids[i], 1'b0, 1'b0);
            checks++; got = snap_a(); exp = mk(ids[i], i + 1, 1, 0, 0, 0, 0);
            if (got !== exp) begin errors++; $display("FAIL push[%0d] got=%h exp=%h", i, got, exp); end
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 0, 1'b1, 1'b0);
            checks++; got = snap_a(); exp = mk(pc[i], 2 - i, (i != 2), 0, 0, 0, 0);
            if (got !== exp) begin errors++; $display("FAIL pop[%0d] got=%h exp=%h", i, got, exp); end
        end
    endtask

    task automatic test_prio_reject();
        do_reset();
        step(1'b1, 5, 1'b0, 1'b0);
        step(1'b1, 3, 1'b0, 1'b0);
        step(1'b1, 4, 1'b0, 1'b0);
        checks++; got = snap_a(); exp = mk(3, 2, 1, 0, 1, 0, 0);
        if (got !== exp) begin errors++; $display("FAIL prio_reject got=%h exp=%h", got, exp); end
        step(1'b0, 0, 1'b0, 1'b0);
        checks++; got = snap_a(); exp = mk(3, 2, 1, 0, 0, 0, 0);
        if (got !== exp) begin errors++; $display("FAIL reject_pulse got=%h exp=%h", got, exp); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, i, 1'b0, 1'b0);
            checks++; got = snap_b(); exp = mk(i, i + 1, 1, (i == 7), 0, 0, 0);
            if (got !== exp) begin errors++; $display("FAIL fill[%0d] got=%h exp=%h", i, got, exp); end
        end
        step(1'b1, 2, 1'b0, 1'b0);
        checks++; got = snap_b(); exp = mk(7, 8, 1, 1, 1, 1, 0);
        if (got !== exp) begin errors++; $display("FAIL overflow got=%h exp=%h", got, exp); end
        step(1'b0, 0, 1'b0, 1'b1);
        checks++; got = snap_b(); exp = mk(7, 8, 1, 1, 0, 0, 0);
        if (got !== exp) begin errors++; $display("FAIL clr_ovf got=%h exp=%h", got, exp); end
        // Replace while full is legal: top swapped, no overflow.
        step(1'b1, 3, 1'b1, 1'b0);
        checks++; got = snap_b(); exp = mk(3, 8, 1, 1, 0, 0, 0);
        if (got !== exp) begin errors++; $display("FAIL full_replace got=%h exp=%h", got, exp); end
        step(1'b0, 0, 1'b1, 1'b0);
        checks++; got = snap_b(); exp = mk(6, 7, 1, 0, 0, 0, 0);
        if (got !== exp) begin errors++; $display("FAIL pop_from_full got=%h exp=%h", got, exp); end
    endtask

    task automatic test_underflow();
        do_reset();
        step(1'b0, 0, 1'b1, 1'b0);
        checks++; got = snap_a(); exp = mk(0, 0, 0, 0, 0, 0, 1);
        if (got !== exp) begin errors++; $display("FAIL underflow got=%h exp=%h", got, exp); end
        step(1'b0, 0, 1'b1, 1'b1);
        checks++; got = snap_a();
        if (got !== exp) begin errors++; $display("FAIL unf_wins_clr got=%h exp=%h", got, exp); end
        step(1'b0, 0, 1'b0, 1'b1);
        checks++; got = snap_a(); exp = mk(0, 0, 0, 0, 0, 0, 0);
        if (got !== exp) begin errors++; $display("FAIL clr_unf got=%h exp=%h", got, exp); end
        step(1'b1, 6, 1'b1, 1'b0);
        checks++; got = snap_a(); exp = mk(6, 1, 1, 0, 0, 0, 1);
        if (got !== exp) begin errors++; $display("FAIL pushpop_empty got=%h exp=%h", got, exp); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        step(1'b1, 6, 1'b0, 1'b0);
        step(1'b1, 2, 1'b0, 1'b0);
        step(1'b1, 5, 1'b1, 1'b0);
        checks++; got = snap_a(); exp = mk(5, 2, 1, 0, 0, 0, 0);
        if (got !== exp) begin errors++; $display("FAIL replace got=%h exp=%h", got, exp); end
        step(1'b0, 0, 1'b1, 1'b0);
        checks++; got = snap_a(); exp = mk(6, 1, 1, 0, 0, 0, 0);
        if (got !== exp) begin errors++; $display("FAIL replace_pop got=%h exp=%h", got, exp); end
    endtask

    task automatic test_async_reset();
        do_reset();
        step(1'b1, 6, 1'b0, 1'b0);
        step(1'b1, 4, 1'b0, 1'b0);
        step(1'b1, 1, 1'b0, 1'b0);
        checks++; got = snap_a(); exp = mk(1, 3, 1, 0, 0, 0, 0);
        if (got !== exp) begin errors++; $display("FAIL pre_async got=%h exp=%h", got, exp); end
        #2 reset = 1'b1;
        #1;
        checks++; got = snap_a(); exp = mk(0, 0, 0, 0, 0, 0, 0);
        if (got !== exp) begin errors++; $display("FAIL async_reset got=%h exp=%h", got, exp); end
        #2 reset = 1'b0;
        step(1'b1, 4, 1'b0, 1'b0);
        checks++; got = snap_a(); exp = mk(4, 1, 1, 0, 0, 0, 0);
        if (got !== exp) begin errors++; $display("FAIL post_reset_push got=%h exp=%h", got, exp); end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_push_pop();
        test_prio_reject();
        test_overflow();
        test_underflow();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
